// File: rtl/onets_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onets_led_pkg
// Description : Shared state encoding, default hold time and a width helper
//               for the OneTSwitch LED/PMOD indicator arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package onets_led_pkg;

    // Arbiter FSM encoding. The GAP state forces one all-off cycle between owners.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } led_state_e;

    // One second of ownership at the 125 MHz fabric clock.
    localparam int HOLD_CYCLES_1S = 125000000;

    // Width of a binary index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : onets_led_pkg
`default_nettype wire

// File: rtl/onets_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onets_rr_arbiter
// Description : Combinational round-robin pick. Returns the first request bit
//               at or after ptr, wrapping at N, as one-hot and binary index.
// Revision    : 1.0  initial release
// ============================================================================
module onets_rr_arbiter
    import onets_led_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);

    // One extra bit so ptr + offset (at most 2N-2) never overflows before wrap.
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_tgt;
    logic             w_found;

    assign any_req = |req;

    // Walk the candidate positions ptr, ptr+1, ... in order and take the first
    // one that is requesting. Both loop indices are constants so every select
    // into req is static.
    always_comb begin
        win     = '0;
        win_idx = '0;
        w_found = 1'b0;
        w_tgt   = '0;
        for (int k = 0; k < N; k++) begin
            w_tgt = {1'b0, ptr} + SUM_W'(k);
            if (w_tgt >= SUM_W'(N)) begin
                w_tgt = w_tgt - SUM_W'(N);
            end
            for (int i = 0; i < N; i++) begin
                if (!w_found && req[i] && (w_tgt == SUM_W'(i))) begin
                    win[i]  = 1'b1;
                    win_idx = IDX_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule : onets_rr_arbiter
`default_nettype wire

// File: rtl/onets_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : onets_led_arbiter
// Description : Time-shares the PL LED/PMOD pins between NUM_REQ requesters.
//               Heartbeat is shown when nobody requests; otherwise each owner
//               gets up to HOLD_CYCLES clocks followed by a one-cycle blank.
//               A PS force path overrides the pins without disturbing the FSM.
// Revision    : 1.0  initial release
// ============================================================================
module onets_led_arbiter
    import onets_led_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LED_W       = 2,
    parameter int HOLD_CYCLES = HOLD_CYCLES_1S
) (
    input  logic                     bd_fclk0_125m,
    input  logic                     rst_n,
    input  logic [LED_W-1:0]         hb_led,
    input  logic                     hb_pmod,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] req_led,
    input  logic [NUM_REQ-1:0]       req_pmod,
    input  logic                     force_en,
    input  logic [LED_W-1:0]         force_led,
    input  logic                     force_pmod,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [LED_W-1:0]         pl_led,
    output logic                     pl_pmod
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    // Counter value seen during the last permitted OWN cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    led_state_e           state_q,    state_d;
    logic [NUM_REQ-1:0]   grant_q,    grant_d;
    logic                 busy_q,     busy_d;
    logic [IDX_W-1:0]     owner_q,    owner_d;
    logic [IDX_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [LED_W-1:0]     pl_led_q,   pl_led_d;
    logic                 pl_pmod_q,  pl_pmod_d;

    // ------------------------------------------------------------------
    // Arbitration and owner data selection
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]   w_win;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_any_req;
    logic [LED_W-1:0]     w_owner_led;
    logic                 w_owner_pmod;
    logic                 w_owner_req;
    logic                 w_release;
    logic [IDX_W-1:0]     w_next_ptr;

    onets_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (rr_ptr_q),
        .win     (w_win),
        .win_idx (w_win_idx),
        .any_req (w_any_req)
    );

    // Select the current owner's request level and indicator values.
    always_comb begin
        w_owner_led  = '0;
        w_owner_pmod = 1'b0;
        w_owner_req  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                w_owner_led  = req_led[i*LED_W +: LED_W];
                w_owner_pmod = req_pmod[i];
                w_owner_req  = req[i];
            end
        end
    end

    // Ownership ends when the owner lets go or its time slice is used up.
    assign w_release  = !w_owner_req || (hold_cnt_q == HOLD_LAST);

    // The pointer moves past the outgoing owner so it goes to the back of the line.
    assign w_next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

    // Next-state, grant, counter and pin values for the arbiter FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        pl_led_d   = '0;
        pl_pmod_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pl_led_d  = hb_led;
                pl_pmod_d = hb_pmod;
                if (w_any_req) begin
                    state_d    = ST_OWN;
                    grant_d    = w_win;
                    owner_d    = w_win_idx;
                    hold_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end

            ST_OWN: begin
                if (w_release) begin
                    state_d  = ST_GAP;
                    grant_d  = '0;
                    rr_ptr_d = w_next_ptr;
                end else begin
                    pl_led_d   = w_owner_led;
                    pl_pmod_d  = w_owner_pmod;
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (w_any_req) begin
                    state_d    = ST_OWN;
                    grant_d    = w_win;
                    owner_d    = w_win_idx;
                    hold_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        // The PS override only replaces the pin values; scheduling carries on.
        if (force_en) begin
            pl_led_d  = force_led;
            pl_pmod_d = force_pmod;
        end
    end

    // Register all FSM state and outputs; reset clears pins immediately.
    always_ff @(posedge bd_fclk0_125m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            pl_led_q   <= '0;
            pl_pmod_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            pl_led_q   <= pl_led_d;
            pl_pmod_q  <= pl_pmod_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign pl_led  = pl_led_q;
    assign pl_pmod = pl_pmod_q;

endmodule : onets_led_arbiter
`default_nettype wire

// File: tb/tb_onets_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_onets_led_arbiter
// Description : Self-checking bench for onets_led_arbiter (4 requesters,
//               2-bit LED, 8-cycle hold). Directed scenarios plus a random run
//               checked every cycle against an ownership-level model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_onets_led_arbiter;

    localparam int N  = 4;
    localparam int LW = 2;
    localparam int H  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [LW-1:0]   hb_led;
    logic            hb_pmod;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_led;
    logic [N-1:0]    req_pmod;
    logic            force_en;
    logic [LW-1:0]   force_led;
    logic            force_pmod;
    logic [N-1:0]    grant;
    logic            busy;
    logic [LW-1:0]   pl_led;
    logic            pl_pmod;

    int n_cmp = 0;
    int n_bad = 0;

    onets_led_arbiter #(
        .NUM_REQ     (N),
        .LED_W       (LW),
        .HOLD_CYCLES (H)
    ) dut (
        .bd_fclk0_125m (clk),
        .rst_n         (rst_n),
        .hb_led        (hb_led),
        .hb_pmod       (hb_pmod),
        .req           (req),
        .req_led       (req_led),
        .req_pmod      (req_pmod),
        .force_en      (force_en),
        .force_led     (force_led),
        .force_pmod    (force_pmod),
        .grant         (grant),
        .busy          (busy),
        .pl_led        (pl_led),
        .pl_pmod       (pl_pmod)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Ownership model: who holds the pins, for how long, and whose turn is next.
    // m_owner = -1 means nobody owns; m_gap marks the blank cycle.
    // ------------------------------------------------------------------
    int            m_owner = -1;
    bit            m_gap   = 1'b0;
    int            m_held  = 0;
    int            m_ptr   = 0;
    logic [LW-1:0] m_led   = '0;
    logic          m_pmod  = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model_and_compare
        logic [LW-1:0] nl;
        logic          np;
        int            w;
        if (!rst_n) begin
            m_owner = -1; m_gap = 1'b0; m_held = 0; m_ptr = 0;
            m_led = '0; m_pmod = 1'b0;
        end else begin
            w = pick(req, m_ptr);
            if (m_gap) begin
                nl = '0; np = 1'b0;
                m_gap = 1'b0; m_owner = w; m_held = 0;
            end else if (m_owner < 0) begin
                nl = hb_led; np = hb_pmod;
                m_owner = w; m_held = 0;
            end else if (!req[m_owner] || m_held == H - 1) begin
                nl = '0; np = 1'b0;
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1'b1;
            end else begin
                nl = req_led[m_owner*LW +: LW]; np = req_pmod[m_owner];
                m_held++;
            end
            if (force_en) begin
                nl = force_led; np = force_pmod;
            end
            m_led = nl; m_pmod = np;
        end
        #1;
        check("m_grant", {28'd0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("m_busy",  {31'd0, busy},  {31'd0, (m_owner >= 0) || m_gap});
        check("m_led",   {30'd0, pl_led}, {30'd0, m_led});
        check("m_pmod",  {31'd0, pl_pmod}, {31'd0, m_pmod});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [N-1:0]  g_log [0:63];
    logic [LW-1:0] l_log [0:63];

    initial begin : stimulus
        int cnt;
        int runs;
        int run_len [0:7];
        logic [N-1:0] order [0:7];
        logic [N-1:0] prev;

        rst_n = 1'b0; req = '0; req_led = '0; req_pmod = '0;
        hb_led = '0; hb_pmod = 1'b0; force_en = 1'b0; force_led = '0; force_pmod = 1'b0;
        step(); step();
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_led",   {30'd0, pl_led}, 32'd0);
        check("rst_pmod",  {31'd0, pl_pmod}, 32'd0);
        rst_n = 1'b1;

        // Heartbeat pass-through while idle
        hb_led = 2'b01; hb_pmod = 1'b1; step();
        check("t1_led_a", {30'd0, pl_led}, 32'h1);
        check("t1_pmod",  {31'd0, pl_pmod}, 32'h1);
        hb_led = 2'b10; hb_pmod = 1'b0; step();
        check("t1_led_b", {30'd0, pl_led}, 32'h2);
        check("t1_grant", {28'd0, grant}, 32'd0);
        check("t1_busy",  {31'd0, busy}, 32'd0);

        // Single requester holds for the full slice, blanks, then regains
        req_led = 8'b0011_0000; req_pmod = 4'b0100; req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            step(); g_log[c] = grant; l_log[c] = pl_led;
        end
        cnt = 0;
        for (int c = 0; c < 8; c++) if (g_log[c] == 4'b0100) cnt++;
        check("t2_own_len", cnt, 8);
        check("t2_gap_grant", {28'd0, g_log[8]}, 32'd0);
        check("t2_gap_led",   {30'd0, l_log[8]}, 32'd0);
        check("t2_own_led",   {30'd0, l_log[4]}, 32'h3);
        check("t2_regrant",   {28'd0, g_log[9]}, 32'h4);
        req = '0;
        repeat (4) step();

        // All requesting from reset: strict rotation starting at requester 0
        do_reset();
        req = 4'b1111; req_led = 8'hE4; req_pmod = 4'b1010;
        for (int c = 0; c < 40; c++) begin
            step(); g_log[c] = grant;
        end
        runs = 0; prev = '0;
        for (int c = 0; c < 40; c++) begin
            if (g_log[c] != 0 && g_log[c] != prev && runs < 8) begin
                order[runs] = g_log[c]; run_len[runs] = 0; runs++;
            end
            if (g_log[c] != 0 && runs > 0) run_len[runs-1]++;
            prev = g_log[c];
        end
        check("t3_runs", runs, 5);
        check("t3_order0", {28'd0, order[0]}, 32'h1);
        check("t3_order1", {28'd0, order[1]}, 32'h2);
        check("t3_order2", {28'd0, order[2]}, 32'h4);
        check("t3_order3", {28'd0, order[3]}, 32'h8);
        check("t3_order4", {28'd0, order[4]}, 32'h1);
        check("t3_len0", run_len[0], 8);
        check("t3_len2", run_len[2], 8);
        req = '0;
        repeat (3) step();

        // Early release hands over after exactly one blank cycle
        do_reset();
        req = 4'b0010; step();
        check("t4_own1", {28'd0, grant}, 32'h2);
        req = 4'b1010; step(); step();
        req = 4'b1000; step();
        check("t4_gap_grant", {28'd0, grant}, 32'd0);
        check("t4_gap_busy",  {31'd0, busy}, 32'h1);
        step();
        check("t4_next", {28'd0, grant}, 32'h8);
        req = '0;
        repeat (3) step();

        // Force overrides the pins while the schedule continues
        do_reset();
        req_led = 8'b0011_0000; req = 4'b0100; step(); step(); step();
        force_en = 1'b1; force_led = 2'b10; force_pmod = 1'b1; step();
        check("t5_force_led", {30'd0, pl_led}, 32'h2);
        check("t5_grant",     {28'd0, grant}, 32'h4);
        repeat (5) step();
        check("t5_gap_grant", {28'd0, grant}, 32'd0);
        check("t5_gap_led",   {30'd0, pl_led}, 32'h2);
        force_en = 1'b0; step();
        check("t5_release_led", {30'd0, pl_led}, 32'd0);
        check("t5_regrant",     {28'd0, grant}, 32'h4);
        step();
        check("t5_owner_led", {30'd0, pl_led}, 32'h3);
        req = '0;
        repeat (3) step();

        // Asynchronous reset in the middle of an ownership
        do_reset();
        req_led = 8'b0000_0001; req_pmod = 4'b0001; req = 4'b0001;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("t6_grant", {28'd0, grant}, 32'd0);
        check("t6_led",   {30'd0, pl_led}, 32'd0);
        check("t6_pmod",  {31'd0, pl_pmod}, 32'd0);
        check("t6_busy",  {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1; step();
        check("t6_regrant", {28'd0, grant}, 32'h1);

        // Random traffic: requests are held for a while, pins and force vary
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 5) == 0);
                else         req[i] = ($urandom_range(0, 19) != 0);
            end
            req_led    = LW'($urandom) == 0 ? 8'($urandom) : req_led ^ 8'($urandom_range(0, 255));
            req_pmod   = 4'($urandom);
            hb_led     = 2'($urandom);
            hb_pmod    = 1'($urandom);
            force_en   = ($urandom_range(0, 15) == 0);
            force_led  = 2'($urandom);
            force_pmod = 1'($urandom);
            rst_n      = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n = 1'b1; req = '0; force_en = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_onets_led_arbiter
`default_nettype wire
